// File: rtl/vdp_host_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdp_host_sequencer                                                       |
// | Expands high-level commands into byte accesses on the tms9918 CPU port.  |
// | Optional shadow register file: define VDP_SEQ_SHADOW_EN.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vdp_host_sequencer #(
  parameter int WR_PULSE = 1,
  parameter int RD_PULSE = 4,
  parameter int GAP      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_op,
  input  logic [13:0] i_cmd_addr,
  input  logic [7:0]  i_cmd_data,
  input  logic [13:0] i_cmd_len,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic        o_busy,
  output logic        o_vdp_mode,
  output logic [7:0]  o_vdp_addr,
  output logic [7:0]  o_vdp_data_in,
  output logic        o_vdp_wr,
  output logic        o_vdp_rd,
  input  logic [15:0] i_vdp_data_out
);

  localparam logic [2:0] c_OP_REG_WR    = 3'd0;
  localparam logic [2:0] c_OP_SET_WADDR = 3'd1;
  localparam logic [2:0] c_OP_SET_RADDR = 3'd2;
  localparam logic [2:0] c_OP_DATA_WR   = 3'd3;
  localparam logic [2:0] c_OP_DATA_RD   = 3'd4;
  localparam logic [2:0] c_OP_STATUS_RD = 3'd5;
  localparam logic [2:0] c_OP_FILL      = 3'd6;
  localparam logic [2:0] c_OP_REG_RD    = 3'd7;

  localparam logic [15:0] c_WR_LAST  = 16'(WR_PULSE - 1);
  localparam logic [15:0] c_RD_LAST  = 16'(RD_PULSE - 1);
  localparam logic [15:0] c_GAP_LAST = 16'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_WSTROBE = 3'd2,
    S_RSTROBE = 3'd3,
    S_GAP     = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  // Access descriptor {is_read, mode, byte} for step n of an op; step 2 is the FILL data phase.
  function automatic logic [9:0] f_access(input logic [2:0] op, input logic [1:0] step,
                                          input logic [13:0] addr, input logic [7:0] data);
    logic [9:0] v;
    v = 10'd0;
    case (op)
      c_OP_REG_WR:    v = (step == 2'd0) ? {1'b0, 1'b1, data}
                                         : {1'b0, 1'b1, 5'b10000, addr[2:0]};
      c_OP_SET_WADDR,
      c_OP_FILL:      v = (step == 2'd0) ? {1'b0, 1'b1, addr[7:0]}
                        : (step == 2'd1) ? {1'b0, 1'b1, 2'b01, addr[13:8]}
                                         : {1'b0, 1'b0, data};
      c_OP_SET_RADDR: v = (step == 2'd0) ? {1'b0, 1'b1, addr[7:0]}
                                         : {1'b0, 1'b1, 2'b00, addr[13:8]};
      c_OP_DATA_WR:   v = {1'b0, 1'b0, data};
      c_OP_DATA_RD:   v = {1'b1, 1'b0, 8'h00};
      c_OP_STATUS_RD: v = {1'b1, 1'b1, 8'h00};
      default:        v = 10'd0;
    endcase
    return v;
  endfunction

  function automatic logic [14:0] f_count(input logic [2:0] op, input logic [13:0] len);
    logic [14:0] n;
    case (op)
      c_OP_REG_WR, c_OP_SET_WADDR, c_OP_SET_RADDR: n = 15'd2;
      c_OP_DATA_WR, c_OP_DATA_RD, c_OP_STATUS_RD:  n = 15'd1;
      c_OP_FILL:                                   n = {1'b0, len} + 15'd2;
      default:                                     n = 15'd0;
    endcase
    return n;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [13:0] r_addr;
  logic [7:0]  r_data;
  logic [1:0]  r_step;
  logic [14:0] r_left;
  logic [15:0] r_cnt;
  logic        r_is_rd;
  logic        r_mode;
  logic [7:0]  r_byte;
  logic [7:0]  r_rsp_data;

  logic        w_accept;
  logic [14:0] w_count;
  logic [9:0]  w_first;
  logic [1:0]  w_step_nxt;
  logic [9:0]  w_next_acc;
  logic        w_more;
  logic        w_gap_done;
  logic        w_shadow_rd;
  logic [7:0]  w_shadow_q;
  logic        w_ready;
  logic        w_wr;
  logic        w_rd;
  logic        w_rsp_valid;
  logic        w_unused_lo;

  assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
  assign w_count     = f_count(i_cmd_op, i_cmd_len);
  assign w_first     = f_access(i_cmd_op, 2'd0, i_cmd_addr, i_cmd_data);
  assign w_step_nxt  = (r_step == 2'd2) ? 2'd2 : r_step + 2'd1;
  assign w_next_acc  = f_access(r_op, w_step_nxt, r_addr, r_data);
  assign w_more      = (r_left != 15'd1);
  assign w_gap_done  = (r_state == S_GAP) && (r_cnt == c_GAP_LAST);
  assign w_unused_lo = ^i_vdp_data_out[7:0];

`ifdef VDP_SEQ_SHADOW_EN
  logic [7:0] r_shadow [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= 8'h00;
    end else if (w_accept && (i_cmd_op == c_OP_REG_WR)) begin
      r_shadow[i_cmd_addr[2:0]] <= i_cmd_data;
    end
  end

  assign w_shadow_rd = w_accept && (i_cmd_op == c_OP_REG_RD);
  assign w_shadow_q  = r_shadow[i_cmd_addr[2:0]];
`else
  assign w_shadow_rd = 1'b0;
  assign w_shadow_q  = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Strobes decode straight from state so an asynchronous reset drops them immediately.
  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          if (w_count != 15'd0) w_next = S_SETUP;
          else if (w_shadow_rd) w_next = S_RESP;
        end
      end
      S_SETUP:   w_next = r_is_rd ? S_RSTROBE : S_WSTROBE;
      S_WSTROBE: begin
        w_wr = 1'b1;
        if (r_cnt == c_WR_LAST) w_next = S_GAP;
      end
      S_RSTROBE: begin
        w_rd = 1'b1;
        if (r_cnt == c_RD_LAST) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          if (w_more)       w_next = S_SETUP;
          else if (r_is_rd) w_next = S_RESP;
          else              w_next = S_IDLE;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= 3'd0;
      r_addr     <= 14'd0;
      r_data     <= 8'h00;
      r_step     <= 2'd0;
      r_left     <= 15'd0;
      r_cnt      <= 16'd0;
      r_is_rd    <= 1'b0;
      r_mode     <= 1'b0;
      r_byte     <= 8'h00;
      r_rsp_data <= 8'h00;
    end else begin
      r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (w_accept) begin
        r_op   <= i_cmd_op;
        r_addr <= i_cmd_addr;
        r_data <= i_cmd_data;
        r_step <= 2'd0;
        r_left <= w_count;
        if (w_count != 15'd0) {r_is_rd, r_mode, r_byte} <= w_first;
      end
      if (w_gap_done && w_more) begin
        r_step                     <= w_step_nxt;
        r_left                     <= r_left - 15'd1;
        {r_is_rd, r_mode, r_byte}  <= w_next_acc;
      end
      if ((r_state == S_RSTROBE) && (r_cnt == c_RD_LAST)) r_rsp_data <= i_vdp_data_out[15:8];
      else if (w_shadow_rd)                               r_rsp_data <= w_shadow_q;
    end
  end

  assign o_cmd_ready   = w_ready;
  assign o_busy        = ~w_ready;
  assign o_rsp_valid   = w_rsp_valid;
  assign o_rsp_data    = r_rsp_data;
  assign o_vdp_mode    = r_mode;
  assign o_vdp_addr    = 8'h00;
  assign o_vdp_data_in = r_byte;
  assign o_vdp_wr      = w_wr;
  assign o_vdp_rd      = w_rd;

endmodule
`default_nettype wire

// File: doc/vdp_host_sequencer.md
Name: vdp_host_sequencer

Overview:
- Command-level front end for the tms9918 CPU port.
- Accepts one high-level command at a time over a valid/ready handshake: register write, VRAM address setup, data read/write, status read, block fill.
- Expands each command into the correctly ordered mode/data_in/wr/rd byte accesses on the VDP's 8-bit port.
- Address and register byte pairs are always issued atomically, so the VDP's two-byte latch can never desynchronise.
- Sits between the CPU bus glue and the tms9918 instance.

Parameters:
- WR_PULSE, 1: clk cycles vdp_wr is held high per write access (min 1).
- RD_PULSE, 4: clk cycles vdp_rd is held high per read access; read data is sampled on the last of these cycles (min 2).
- GAP, 2: idle clk cycles after each strobe before the next access or return to IDLE (min 1).

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain).
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_op  in  3  0 REG_WR, 1 SET_WADDR, 2 SET_RADDR, 3 DATA_WR, 4 DATA_RD, 5 STATUS_RD, 6 FILL, 7 REG_RD (see Optional Feature).
- cmd_addr  in  14  VRAM address (ops 1, 2, 6); register number in [2:0] (ops 0, 7).
- cmd_data  in  8  register value or data byte.
- cmd_len  in  14  FILL byte count.
- rsp_valid  out  1  one-cycle pulse carrying read result; no backpressure.
- rsp_data  out  8  read result; holds its value until the next response.
- busy  out  1  equals not cmd_ready.
- vdp_mode  out  1  1 = register/address port, 0 = VRAM data port.
- vdp_addr  out  8  tied to 0.
- vdp_data_in  out  8  byte driven to the VDP.
- vdp_wr  out  1  write strobe.
- vdp_rd  out  1  read strobe.
- vdp_data_out  in  16  VDP read data; only bits [15:8] are used.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - State forced to IDLE.
  - vdp_wr, vdp_rd, vdp_mode, vdp_data_in, rsp_valid, rsp_data, busy all 0.
  - cmd_ready = 1.
  - No partial access is resumed after reset is released.
- States: IDLE, SETUP, WSTROBE, RSTROBE, GAP, RESP.
- Write access:
  - SETUP, 1 cycle: drive vdp_mode and vdp_data_in, vdp_wr = 0.
  - WSTROBE: vdp_wr = 1 for WR_PULSE cycles.
  - GAP: GAP cycles.
  - mode and data are held stable through all three phases.
- Read access:
  - SETUP, 1 cycle, then RSTROBE with vdp_rd = 1 for RD_PULSE cycles.
  - rsp_data <= vdp_data_out[15:8] on the last RSTROBE cycle.
  - GAP, then RESP: rsp_valid = 1 for one cycle, then IDLE.
- Byte sequence per op (m = vdp_mode):
  - REG_WR: (m1, cmd_data), (m1, 0x80 | reg).
  - SET_WADDR: (m1, addr[7:0]), (m1, {01, addr[13:8]}).
  - SET_RADDR: (m1, addr[7:0]), (m1, {00, addr[13:8]}).
  - DATA_WR: (m0, cmd_data).
  - DATA_RD: read with m0.
  - STATUS_RD: read with m1.
  - FILL: the SET_WADDR pair, then cmd_len writes of (m0, cmd_data).
- Command capture:
  - cmd_op, cmd_addr, cmd_data and cmd_len are registered in the accept cycle; later input changes are ignored.
  - The first SETUP is the cycle after accept.
- Latency at defaults (WR_PULSE 1, GAP 2): 4 cycles per write access.
  - REG_WR: cmd_ready low for 8 cycles.
  - FILL of length N: low for 8 + 4N cycles.
  - DATA_RD: rsp_valid on cycle 1 + 4 + 2 + 1 = 8 after accept.
- Boundaries:
  - FILL with cmd_len = 0 issues only the address pair.
  - FILL crossing 0x3FFF is not checked; the VDP's internal counter wraps.
  - cmd_valid while busy is ignored and not queued.
  - cmd_valid can be held high continuously; back-to-back commands start one cycle after IDLE is re-entered.
  - Any op with no defined sequence is accepted and completes in 1 cycle with no VDP activity and no response.

Optional Feature:
- Macro: VDP_SEQ_SHADOW_EN.
- Defined:
  - An 8x8 shadow register file is updated by every REG_WR.
  - REG_RD returns shadow[cmd_addr[2:0]] with rsp_valid 1 cycle after accept, with no VDP access.
  - The shadow file resets to 0.
- Not defined:
  - No shadow storage is built.
  - REG_RD behaves as an undefined op: 1-cycle no-op, no response.

Test Plan:
- REG_WR reg 1, data 0xEA -> vdp_mode = 1 writes 0xEA then 0x81, 4 cycles apart; cmd_ready low for 8 cycles. With VDP_SEQ_SHADOW_EN, a following REG_RD reg 1 -> rsp_data 0xEA.
- With a tms9918 instance: SET_WADDR 0x1234, DATA_WR 0x5A, DATA_WR 0xEE, SET_RADDR 0x1234, DATA_RD, DATA_RD -> rsp_data 0x5A then 0xEE.
- FILL addr 0x0800, len 32, data 0x00 -> writes 0x00 then 0x48 with m1, then 32 m0 writes of 0x00; total 34 wr pulses; busy for 136 cycles.
- FILL addr 0x1000, len 0 -> exactly 2 wr pulses (0x00, 0x50), no m0 writes.
- STATUS_RD after 17 ms of video -> rsp_data[7] = 1; an immediate second STATUS_RD -> rsp_data[7] = 0.
- Assert reset low mid-FILL during WSTROBE -> vdp_wr drops in the same cycle. After release, cmd_ready = 1, and REG_WR reg 7 value 0xF4 produces the bytes 0xF4 then 0x87.
